mul16_sequencer: RTL
====================

MUL16_SEQUENCER -- requirements
Module: mul16_sequencer

Interface
REQ-001 Parameter MULT_LAT, default 1: cycles from operands applied to the mult8x8 instance until its P output is valid; legal range 1..4.
REQ-002 CLOCK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset; sampled on rising edge of CLOCK.
REQ-004 REQ_VALID  input  1  requester presents operands A, B.
REQ-005 REQ_READY  output  1  block can accept a request this cycle.
REQ-006 A  input  16  unsigned multiplicand; sampled only on acceptance.
REQ-007 B  input  16  unsigned multiplier; sampled only on acceptance.
REQ-008 RES_VALID  output  1  P holds a completed product.
REQ-009 RES_READY  input  1  consumer accepts P.
REQ-010 P  output  32  unsigned product A*B.
REQ-011 BUSY  output  1  high in any state other than IDLE.

Function
REQ-012 States: IDLE, RUN, DONE; encoding is binary.
REQ-013 REQ_READY SHALL be 1 exactly when the state is IDLE; acceptance is REQ_VALID && REQ_READY at a rising edge.
REQ-014 On acceptance, A and B SHALL be latched into internal registers AR, BR, the accumulator SHALL clear to 0, the step counter SHALL clear to 0, and the state SHALL go to RUN.
REQ-015 In RUN, one 8x8 operand pair SHALL be issued to the single mult8x8 instance per cycle, in order: step0 AR[7:0]*BR[7:0], step1 AR[7:0]*BR[15:8], step2 AR[15:8]*BR[7:0], step3 AR[15:8]*BR[15:8].
REQ-016 The mult8x8 output for step i SHALL be captured MULT_LAT cycles after issue and added to the accumulator shifted left by 0, 8, 8, 16 bits for steps 0..3 respectively.
REQ-017 Accumulation SHALL be 32 bits wide; the final sum equals A*B exactly, with no overflow possible.
REQ-018 RUN SHALL last exactly 4+MULT_LAT cycles; with MULT_LAT=1, RES_VALID SHALL be high in the 6th cycle after the acceptance edge (acceptance edge E0, DONE entered at edge E0+5).
REQ-019 Issue and capture SHALL overlap (pipelined): issuing step i+1 in the same cycle as capturing step i+1-MULT_LAT SHALL NOT stall.
REQ-020 In DONE, RES_VALID SHALL be 1 and P SHALL hold the final accumulator; P and RES_VALID SHALL remain stable until RES_READY is sampled high.
REQ-021 A DONE-state edge with RES_READY=1 SHALL return the block to IDLE; a new request is accepted no earlier than the following edge.
REQ-022 RES_READY outside DONE SHALL be ignored; REQ_VALID outside IDLE SHALL be ignored, and A/B changes during RUN SHALL NOT affect the result.
REQ-023 P SHALL hold its last value after the handshake until the next result overwrites it.
REQ-024 Operand inputs to mult8x8 SHALL be driven to 0 when no step is being issued.

Reset
REQ-025 RESET=1 at an edge SHALL force state to IDLE, step counter to 0, accumulator and P to 0, AR and BR to 0, RES_VALID to 0, and BUSY to 0.
REQ-026 RESET SHALL take priority over every other input at the same edge, including mid-RUN and in DONE; an in-flight product is discarded with no RES_VALID pulse.
REQ-027 REQ_READY SHALL be 1 in the first cycle after RESET deasserts.

Structure
REQ-028 The state encoding, the operand width (8), the result width (32), and the step count (4) SHALL live in a shared package, mul_pkg, for reuse by the CPU datapath.
REQ-029 The block SHALL instantiate exactly one existing mult8x8 sub-module, clocked by CLOCK; no other multiplier logic is permitted.
REQ-030 The step counter SHALL be 3 bits wide, sized to count 4+MULT_LAT at MULT_LAT=4.

Verification
REQ-031 A=0x1234, B=0x5678, RES_READY=1 -> P=0x06260060, RES_VALID high 6 cycles after acceptance for one cycle, then REQ_READY=1.
REQ-032 A=0xFFFF, B=0xFFFF -> P=0xFFFE0001; A=0x0100, B=0x0100 -> P=0x00010000; A=0x0000, B=0xBEEF -> P=0x00000000.
REQ-033 RES_READY held 0 for 10 cycles after DONE -> P and RES_VALID stable throughout; REQ_VALID=1 with new operands in that window is not accepted (REQ_READY=0).
REQ-034 RESET asserted for one edge at the 3rd RUN cycle -> next cycle: BUSY=0, REQ_READY=1, P=0; no RES_VALID pulse; a following request 0x0003*0x0005 yields P=0x0000000F.
REQ-035 A/B toggled randomly during RUN after accepting 0x00FF*0x0101 -> P=0x0000FFFF.
REQ-036 Back-to-back: 2nd request held valid during 1st result handshake -> accepted at the edge after DONE exits; both results correct and in order.

Source files
------------

// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the 16x16 sequenced multiplier and for any CPU
// datapath logic that needs to talk to it.
//
// Contents:
//   OPER_W      width of one operand slice fed to the 8x8 multiplier (8)
//   IN_W        width of a full operand (16)
//   PROD_W      width of one 8x8 partial product (16)
//   RES_W       width of the final product / accumulator (32)
//   NUM_STEPS   number of partial products per multiplication (4)
//   STEP_CNT_W  step counter width; holds 4+MULT_LAT-1 for MULT_LAT up to 4
//   seq_state_t sequencer state encoding (binary)
//   step_shift  left shift applied to the partial product of a given step
//   step_a_hi   step uses the upper byte of the multiplicand
//   step_b_hi   step uses the upper byte of the multiplier
// -----------------------------------------------------------------------------
package mul_pkg;

    localparam int OPER_W     = 8;
    localparam int IN_W       = 2 * OPER_W;
    localparam int PROD_W     = 2 * OPER_W;
    localparam int RES_W      = 32;
    localparam int NUM_STEPS  = 4;
    localparam int STEP_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Partial-product weights for the step order lo*lo, lo*hi, hi*lo, hi*hi.
    function automatic logic [4:0] step_shift(input logic [1:0] step);
        logic [4:0] shamt;
        case (step)
            2'd0:    shamt = 5'd0;
            2'd3:    shamt = 5'd16;
            default: shamt = 5'd8;
        endcase
        return shamt;
    endfunction

    // Steps 2 and 3 take the upper multiplicand byte.
    function automatic logic step_a_hi(input logic [1:0] step);
        return step[1];
    endfunction

    // Steps 1 and 3 take the upper multiplier byte.
    function automatic logic step_b_hi(input logic [1:0] step);
        return step[0];
    endfunction

endpackage

// File: rtl/mul16_sequencer_mult8x8.sv
// -----------------------------------------------------------------------------
// mult8x8
// Pipelined unsigned 8x8 multiplier. The product of operands presented in a
// cycle appears on p LAT cycles later; a new operand pair may be presented
// every cycle.
//
// Parameters:
//   LAT  pipeline depth in cycles (1..4)
// Ports:
//   clk  input   rising-edge clock
//   a    input   8-bit unsigned operand
//   b    input   8-bit unsigned operand
//   p    output  16-bit unsigned product, delayed by LAT cycles
// -----------------------------------------------------------------------------
module mult8x8
    import mul_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic              clk,
    input  logic [OPER_W-1:0] a,
    input  logic [OPER_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    logic [PROD_W-1:0] pipe_q [LAT];
    logic [PROD_W-1:0] pipe_d [LAT];

    // The product enters stage 0 and then ripples down the delay line. The
    // pipeline needs no reset: the sequencer only samples p after it has
    // issued a fresh operand pair at least LAT cycles earlier.
    always_comb begin
        pipe_d[0] = PROD_W'(a) * PROD_W'(b);
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe_q <= pipe_d;
    end

    assign p = pipe_q[LAT-1];

endmodule

// File: rtl/mul16_sequencer.sv
// -----------------------------------------------------------------------------
// mul16_sequencer
// Computes a 16x16 -> 32 unsigned product with a single shared 8x8 multiplier
// by issuing the four byte-pair partial products on consecutive cycles and
// summing them, suitably shifted, into a 32-bit accumulator.
//
// Parameters:
//   MULT_LAT   latency of the mult8x8 instance in cycles (1..4)
// Ports:
//   CLOCK      input   rising-edge clock
//   RESET      input   synchronous active-high reset
//   REQ_VALID  input   request with operands A, B is present
//   REQ_READY  output  block accepts a request this cycle (IDLE only)
//   A, B       input   16-bit unsigned operands, sampled on acceptance
//   RES_VALID  output  P holds a completed product (DONE only)
//   RES_READY  input   consumer takes P
//   P          output  32-bit product; holds its value until overwritten
//   BUSY       output  block is not IDLE
// -----------------------------------------------------------------------------
module mul16_sequencer
    import mul_pkg::*;
#(
    parameter int MULT_LAT = 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [IN_W-1:0]  A,
    input  logic [IN_W-1:0]  B,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [RES_W-1:0] P,
    output logic             BUSY
);

    // Step counter values: issues happen while the count is below
    // NUM_STEPS, captures once it has reached MULT_LAT, and the final capture
    // (and exit from RUN) happens at NUM_STEPS-1+MULT_LAT.
    localparam logic [STEP_CNT_W-1:0] LAT_CNT   = STEP_CNT_W'(MULT_LAT);
    localparam logic [STEP_CNT_W-1:0] ISSUE_END = STEP_CNT_W'(NUM_STEPS);
    localparam logic [STEP_CNT_W-1:0] LAST_CNT  = STEP_CNT_W'(NUM_STEPS - 1 + MULT_LAT);

    seq_state_t              state_q, state_d;
    logic [STEP_CNT_W-1:0]   step_q,  step_d;
    logic [IN_W-1:0]         ar_q,    ar_d;
    logic [IN_W-1:0]         br_q,    br_d;
    logic [RES_W-1:0]        acc_q,   acc_d;
    logic [RES_W-1:0]        p_q,     p_d;

    logic                    issue_en;
    logic                    capture_en;
    logic [1:0]              issue_idx;
    logic [1:0]              capture_idx;
    logic [OPER_W-1:0]       mul_a;
    logic [OPER_W-1:0]       mul_b;
    logic [PROD_W-1:0]       mul_p;
    logic [RES_W-1:0]        addend;
    logic [RES_W-1:0]        acc_sum;

    // Issue and capture windows overlap, so the multiplier is fed every
    // cycle while earlier products are still being accumulated. The capture
    // index wraps modulo 4, which is exact because the count minus MULT_LAT
    // is always 0..3 inside the capture window.
    always_comb begin
        issue_en    = (state_q == ST_RUN) && (step_q < ISSUE_END);
        capture_en  = (state_q == ST_RUN) && (step_q >= LAT_CNT);
        issue_idx   = step_q[1:0];
        capture_idx = step_q[1:0] - LAT_CNT[1:0];
    end

    // Byte selection for the current issue; operands sit at zero whenever
    // nothing is being issued so the multiplier input is quiet.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (issue_en) begin
            mul_a = step_a_hi(issue_idx) ? ar_q[IN_W-1:OPER_W] : ar_q[OPER_W-1:0];
            mul_b = step_b_hi(issue_idx) ? br_q[IN_W-1:OPER_W] : br_q[OPER_W-1:0];
        end
    end

    mult8x8 #(
        .LAT (MULT_LAT)
    ) u_mult8x8 (
        .clk (CLOCK),
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p)
    );

    // The shifted partial product is added to the running sum. The sum of
    // all four weighted products is A*B, which always fits in 32 bits.
    always_comb begin
        addend  = RES_W'(mul_p) << step_shift(capture_idx);
        acc_sum = acc_q + addend;
    end

    // Next-state logic. P is a separate register from the accumulator so
    // that the previous result stays visible while the next one is built.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        ar_d    = ar_q;
        br_d    = br_q;
        acc_d   = acc_q;
        p_d     = p_q;

        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    ar_d    = A;
                    br_d    = B;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                step_d = step_q + 1'b1;
                if (capture_en) begin
                    acc_d = acc_sum;
                end
                if (step_q == LAST_CNT) begin
                    p_d     = acc_sum;
                    step_d  = '0;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (RES_READY) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Reset wins over everything, discarding any product in flight.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            ar_q    <= '0;
            br_q    <= '0;
            acc_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            ar_q    <= ar_d;
            br_q    <= br_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
        end
    end

    assign REQ_READY = (state_q == ST_IDLE);
    assign RES_VALID = (state_q == ST_DONE);
    assign BUSY      = (state_q != ST_IDLE);
    assign P         = p_q;

endmodule
